// File: rtl/serial_adder_if.sv
// Bus bundle for serial_adder: operand request side and result side.
// master = requester driving operands, slave = the adder itself.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is a level request sampled only while the adder is idle
  // (busy=0); a, b, c_in and sub are captured on the same edge that accepts
  // start and may change freely afterwards. done pulses for exactly one cycle
  // when sum/c_out/ovf become valid. Those results hold until the next accept.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit add done CHUNK bits per clock through one ripple slice.
// Optional subtraction is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4   // WIDTH must be a multiple of CHUNK
) (
  input  logic        clk,
  input  logic        reset,
  serial_adder_if.slave bus,
  output logic [1:0]  dbg_state
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, c_out_q, ovf_q;
  logic [IDX_W-1:0] idx_q;

  logic             load, step, last;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_carry_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1   : bus.c_in;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.c_in;
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  // Select the operand chunk addressed by idx; all bases are constants.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign chunk_sum    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit recovered from that bit's own sum: s = a ^ b ^ cin.
  assign msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = (idx_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (load) begin
      a_q     <= bus.a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      idx_q   <= '0;
    end else if (step) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (idx_q == IDX_W'(k)) sum_q[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
      end
      carry_q <= chunk_sum[CHUNK];
      idx_q   <= idx_q + IDX_W'(1);
      if (last) begin
        c_out_q <= chunk_sum[CHUNK];
        ovf_q   <= msb_carry_in ^ chunk_sum[CHUNK];
      end
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: four instances (CHUNK 4, 1, 8, 16) share one stimulus.
// Build with +define+SERIAL_ADDER_SUB_EN to exercise the subtraction vectors.
module tb_serial_adder;
  localparam int W = 16;
  localparam int NI = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start, c_in, sub;
  logic [W-1:0] a, b;

  logic [NI-1:0] busy_v, done_v, cout_v, ovf_v;
  logic [W-1:0]  sum_v [NI];
  logic [1:0]    st_v  [NI];

  int chunk_of [NI] = '{4, 1, 8, 16};
  int lat_exp  [NI] = '{5, 17, 3, 2};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
    serial_adder_if #(.WIDTH(W)) bus ();
    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.c_in  = c_in;
    assign bus.sub   = sub;
    serial_adder #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (st_v[g])
    );
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.c_out;
    assign ovf_v[g]  = bus.ovf;
    assign sum_v[g]  = bus.sum;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issues one operation on all instances and checks each result after a fixed window.
  // With glitch=1 a conflicting start is presented while the instances are busy.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic vsub, input logic [W-1:0] esum,
                        input logic ecout, input logic eovf, input bit glitch);
    int lat [NI];
    int dones [NI];
    int busys [NI];
    logic [W-1:0] exp_sum;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0; dones[i] = 0; busys[i] = 0;
    end
    exp_q.push_back(esum);
    a = va; b = vb; c_in = vcin; sub = vsub; start = 1'b1;
    for (int cnt = 1; cnt <= 22; cnt++) begin
      @(posedge clk); #1;
      if (cnt == 1) start = 1'b0;
      if (glitch && cnt == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      end
      if (glitch && cnt == 3) start = 1'b0;
      for (int i = 0; i < NI; i++) begin
        if (done_v[i]) begin
          dones[i]++;
          if (lat[i] == 0) lat[i] = cnt;
        end
        if (busy_v[i]) busys[i]++;
      end
    end
    exp_sum = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s sum c%0d", name, chunk_of[i]), 32'(sum_v[i]), 32'(exp_sum));
      check($sformatf("%s c_out c%0d", name, chunk_of[i]), 32'(cout_v[i]), 32'(ecout));
      check($sformatf("%s ovf c%0d", name, chunk_of[i]), 32'(ovf_v[i]), 32'(eovf));
      check($sformatf("%s latency c%0d", name, chunk_of[i]), 32'(lat[i]), 32'(lat_exp[i]));
      check($sformatf("%s done_pulses c%0d", name, chunk_of[i]), 32'(dones[i]), 32'd1);
      check($sformatf("%s busy_cycles c%0d", name, chunk_of[i]), 32'(busys[i]), 32'(lat_exp[i]));
      check($sformatf("%s idle c%0d", name, chunk_of[i]), 32'(st_v[i]), 32'd0);
    end
  endtask

  // Starts an operation, then asserts reset two cycles into RUN.
  task automatic reset_mid_run();
    int dones [NI];
    for (int i = 0; i < NI; i++) dones[i] = 0;
    a = 16'h1234; b = 16'h0FFF; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    for (int cnt = 1; cnt <= 3; cnt++) begin
      @(posedge clk); #1;
      if (cnt == 1) start = 1'b0;
      if (cnt == 2) reset = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_mid busy c%0d", chunk_of[i]), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst_mid done c%0d", chunk_of[i]), 32'(done_v[i]), 32'd0);
      check($sformatf("rst_mid sum c%0d", chunk_of[i]), 32'(sum_v[i]), 32'd0);
    end
    reset = 1'b0;
    for (int cnt = 0; cnt < 20; cnt++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) if (done_v[i]) dones[i]++;
    end
    for (int i = 0; i < NI; i++)
      check($sformatf("rst_mid no_done c%0d", chunk_of[i]), 32'(dones[i]), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset sum c%0d", chunk_of[i]), 32'(sum_v[i]), 32'd0);
      check($sformatf("reset busy c%0d", chunk_of[i]), 32'(busy_v[i]), 32'd0);
      check($sformatf("reset done c%0d", chunk_of[i]), 32'(done_v[i]), 32'd0);
      check($sformatf("reset c_out c%0d", chunk_of[i]), 32'(cout_v[i]), 32'd0);
      check($sformatf("reset ovf c%0d", chunk_of[i]), 32'(ovf_v[i]), 32'd0);
      check($sformatf("reset state c%0d", chunk_of[i]), 32'(st_v[i]), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("basic",     16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("cin_only",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op("mixed_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_pos",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`else
    run_op("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    run_op("sub_ign_msb", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0);
`endif
    run_op("busy_start", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    reset_mid_run();
    run_op("after_rst", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
